regfile: RTL and testbench
==========================

# regfile

General-purpose register file at the write-back end of the five-stage pipeline. It accepts the write-back triple registered by the MEM/WB stage register (destination address, data, write enable) and serves two combinational read ports to the decode stage. A same-cycle write-to-read bypass removes the WB→ID hazard. An optional dump engine streams the whole register array out over a valid/ready handshake for debug.

## Interface
- DATA_W, 32: register width in bits.
- REG_NUM, 32: number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5: log2(REG_NUM).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- we  in  1  write enable, from the write-back stage.
- waddr  in  ADDR_W  write destination register.
- wdata  in  DATA_W  write data.
- re1 / re2  in  1  read enables, ports 1 and 2, from decode.
- raddr1 / raddr2  in  ADDR_W  read addresses.
- rdata1 / rdata2  out  DATA_W  read data; combinational.
- dump_req  in  1  one-cycle request to start a dump (REGFILE_DUMP_EN only).
- dump_ready  in  1  consumer accepts the current dump beat (REGFILE_DUMP_EN only).
- dump_valid  out  1  dump beat valid (REGFILE_DUMP_EN only).
- dump_addr  out  ADDR_W  register index of the current beat (REGFILE_DUMP_EN only).
- dump_data  out  DATA_W  register value of the current beat (REGFILE_DUMP_EN only).
- dump_busy  out  1  dump in progress (REGFILE_DUMP_EN only).

## Operation
- Write: on a rising edge with rst=0, we=1 and waddr≠0, reg[waddr] takes wdata. Writes to register 0 are discarded.
- Read port n, in priority order:
  - rst=1 → 0.
  - re_n=0 → 0.
  - raddr_n=0 → 0.
  - we=1 and waddr=raddr_n → wdata (bypass).
  - otherwise → reg[raddr_n].
- Both ports are independent and may read the same address.
- Dump FSM, states IDLE and SEND:
  - IDLE: dump_valid=0, dump_busy=0. dump_req=1 → SEND with idx=0.
  - SEND: dump_valid=1, dump_busy=1, dump_addr=idx, dump_data = read of idx using the same bypass rule (re treated as 1).
  - SEND, on dump_valid & dump_ready: if idx=REG_NUM-1 → IDLE, else idx+1.
  - SEND, dump_ready=0: hold; dump_addr is stable, and dump_data may change only by a write to idx.
  - dump_req while in SEND is ignored.
- Writes proceed normally during a dump. Each beat returns the value current in its handshake cycle.

## Timing
- Read latency: 0 cycles (combinational). Write latency: visible through the array on the cycle after the edge, and through the bypass in the same cycle.
- Reset state: all REG_NUM registers 0, FSM IDLE, idx=0.
- Reset output values: rdata1=rdata2=0, dump_valid=0, dump_busy=0, dump_addr=0, dump_data=0.
- Reset mid-dump aborts the dump. The FSM is in IDLE on the first cycle after rst deasserts, and no further beats are sent.
- A full dump with dump_ready held at 1 takes REG_NUM cycles of dump_valid. dump_busy falls on the cycle after the last handshake.
- dump_req in the same cycle as the final handshake is ignored. A new request is accepted only in IDLE.

## Configuration
- REGFILE_DUMP_EN defined: the dump ports and the FSM exist.
- REGFILE_DUMP_EN undefined: the dump ports are absent from the port list and no dump logic is built. Read/write behaviour is unchanged.

## Structure
- The shared defines package holds:
  - widths: RegBus, RegAddrBus, RegNum, RegNumLog2;
  - constants: ZeroWord, NOPRegAddr, WriteEnable, ReadEnable, RstEnable;
  - dump FSM state encodings.
- Sub-module regfile_dump: holds the FSM, idx counter and handshake. It issues a third read address into the parent's bypassed read mux and is instantiated only under REGFILE_DUMP_EN.

## Test plan
- Reset, then read all addresses on both ports → every rdata = 0x00000000.
- Write 0xDEADBEEF to r5 with raddr1=5, re1=1 in the same cycle → rdata1=0xDEADBEEF that cycle. After we drops, rdata1 still reads 0xDEADBEEF.
- Write 0x12345678 to r0, then read r0 on both ports → 0x00000000. With re2=0 and raddr2=5 → rdata2=0.
- Load r1..r31 with value = 0x100+i, pulse dump_req, hold dump_ready=1 → 32 beats in consecutive cycles with addr 0..31, data 0, 0x101..0x11F. dump_busy is low after the last beat.
- During a dump, stall dump_ready=0 at idx=7 while writing 0xCAFEF00D to r7 → the held beat shows addr=7, data=0xCAFEF00D. A dump_req pulse during the stall has no effect.
- Assert rst at idx=12 → dump_valid=0 and dump_busy=0 the next cycle and all registers read 0. A new dump_req restarts at addr=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, constants and dump FSM encodings for the register file.
package regfile_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  localparam logic [RegBus-1:0]     ZeroWord    = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr  = '0;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic                  ReadEnable  = 1'b1;
  localparam logic                  RstEnable   = 1'b1;

  typedef enum logic {
    DUMP_IDLE = 1'b0,
    DUMP_SEND = 1'b1
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Debug dump engine: walks idx 0..REG_NUM-1, one beat per valid/ready handshake.
// Reads through the parent's bypassed mux so each beat shows the value current in its cycle.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RegBus,
  parameter int ADDR_W  = RegNumLog2,
  parameter int REG_NUM = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              dump_valid,
  output logic              dump_busy,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(REG_NUM - 1);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= DUMP_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_data  = '0;
    case (state)
      DUMP_IDLE: begin
        if (dump_req) begin
          state_nxt = DUMP_SEND;
          idx_nxt   = '0;
        end
      end
      DUMP_SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        dump_data  = rd_data;
        // Requests arriving here, including on the final handshake, are dropped.
        if (dump_ready) begin
          if (idx == LastIdx) begin
            state_nxt = DUMP_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = DUMP_IDLE;
    endcase
    if (rst == RstEnable) begin
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      dump_data  = '0;
    end
  end

  assign rd_addr   = idx;
  assign dump_addr = (rst == RstEnable) ? '0 : idx;

endmodule

// File: rtl/regfile.sv
// Write-back register file: r0 hardwired zero, two combinational read ports with WB->ID bypass.
// Optional debug dump streaming engine built only when REGFILE_DUMP_EN is defined.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RegBus,
  parameter int REG_NUM = RegNum,
  parameter int ADDR_W  = RegNumLog2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_DUMP_EN
  ,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy
`endif
);

`ifdef REGFILE_DUMP_EN
  localparam int NPORT = 3;
`else
  localparam int NPORT = 2;
`endif

  logic [DATA_W-1:0] regs [REG_NUM];
  logic              rd_en   [NPORT];
  logic [ADDR_W-1:0] rd_addr [NPORT];
  logic [DATA_W-1:0] rd_data [NPORT];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we == WriteEnable && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd_en[0]   = re1;
  assign rd_addr[0] = raddr1;
  assign rd_en[1]   = re2;
  assign rd_addr[1] = raddr2;

  // Same-cycle write wins over the array so decode sees WB results without a stall.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      if (rst == RstEnable || rd_en[p] != ReadEnable || rd_addr[p] == '0)
        rd_data[p] = '0;
      else if (we == WriteEnable && waddr == rd_addr[p])
        rd_data[p] = wdata;
      else
        rd_data[p] = regs[rd_addr[p]];
    end
  end

  assign rdata1 = rd_data[0];
  assign rdata2 = rd_data[1];

`ifdef REGFILE_DUMP_EN
  assign rd_en[2] = ReadEnable;

  regfile_dump #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_NUM(REG_NUM)
  ) u_dump (
    .clk       (clk),
    .rst       (rst),
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .rd_data   (rd_data[2]),
    .rd_addr   (rd_addr[2]),
    .dump_valid(dump_valid),
    .dump_busy (dump_busy),
    .dump_addr (dump_addr),
    .dump_data (dump_data)
  );
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile; dump scenarios run when REGFILE_DUMP_EN is defined.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst, we, re1, re2;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
`ifdef REGFILE_DUMP_EN
  logic        dump_req, dump_ready, dump_valid, dump_busy;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];
  bit          d_active;
  int          d_idx;

  always #5 clk = ~clk;

  regfile dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re1   (re1),
    .raddr1(raddr1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata1(rdata1),
    .rdata2(rdata2)
`ifdef REGFILE_DUMP_EN
    ,
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_busy (dump_busy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'd0;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  // Advance one clock edge, applying the architectural effect of the current inputs.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      d_active = 0;
      d_idx    = 0;
    end else begin
      if (we && waddr != 5'd0) model[waddr] = wdata;
`ifdef REGFILE_DUMP_EN
      if (d_active) begin
        if (dump_ready) begin
          if (d_idx == 31) begin
            d_active = 0;
            d_idx    = 0;
          end else begin
            d_idx++;
          end
        end
      end else if (dump_req) begin
        d_active = 1;
        d_idx    = 0;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    chk("rd1", rdata1, exp_rd(re1, raddr1));
    chk("rd2", rdata2, exp_rd(re2, raddr2));
`ifdef REGFILE_DUMP_EN
    chk("dvalid", {31'd0, dump_valid}, {31'd0, (d_active && !rst)});
    chk("dbusy", {31'd0, dump_busy}, {31'd0, (d_active && !rst)});
    if (d_active && !rst) begin
      chk("daddr", {27'd0, dump_addr}, d_idx);
      chk("ddata", dump_data, exp_rd(1'b1, 5'(d_idx)));
    end
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; we = 0; waddr = 0; wdata = 0;
    re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
`ifdef REGFILE_DUMP_EN
    dump_req = 0; dump_ready = 0;
`endif
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    d_active = 0; d_idx = 0;
    tick(); tick();

    // Reads are forced to zero while reset is held, even with a pending bypass.
    re1 = 1; re2 = 1; raddr1 = 5'd3; raddr2 = 5'd9;
    we = 1; waddr = 5'd9; wdata = 32'hFFFF0000;
    #1;
    chk("rst_rd1", rdata1, 32'd0);
    chk("rst_rd2", rdata2, 32'd0);
`ifdef REGFILE_DUMP_EN
    chk("rst_dvalid", {31'd0, dump_valid}, 32'd0);
    chk("rst_dbusy", {31'd0, dump_busy}, 32'd0);
    chk("rst_daddr", {27'd0, dump_addr}, 32'd0);
    chk("rst_ddata", dump_data, 32'd0);
`endif
    tick();
    rst = 0; we = 0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      chk("init_rd1", rdata1, 32'd0);
      chk("init_rd2", rdata2, 32'd0);
    end

    // Bypass in the write cycle, then array after the edge.
    we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; re1 = 1;
    #1;
    chk("bypass_rd1", rdata1, 32'hDEADBEEF);
    tick();
    we = 0;
    #1;
    chk("array_rd1", rdata1, 32'hDEADBEEF);

    // r0 stays zero; disabled port reads zero.
    we = 1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0; raddr2 = 5'd0; re2 = 1;
    #1;
    chk("r0_byp_rd1", rdata1, 32'd0);
    chk("r0_byp_rd2", rdata2, 32'd0);
    tick();
    we = 0;
    #1;
    chk("r0_rd1", rdata1, 32'd0);
    chk("r0_rd2", rdata2, 32'd0);
    re2 = 0; raddr2 = 5'd5;
    #1;
    chk("re2_off", rdata2, 32'd0);
    re2 = 1;
    #1;
    chk("re2_on", rdata2, 32'hDEADBEEF);
    tick();

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 63) == 0);
      we     = $urandom_range(0, 1);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 7) != 0);
      re2    = ($urandom_range(0, 7) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
`ifdef REGFILE_DUMP_EN
      dump_req   = ($urandom_range(0, 15) == 0);
      dump_ready = $urandom_range(0, 1);
`endif
      #1;
      check_all();
      tick();
    end

    rst = 1; we = 0;
`ifdef REGFILE_DUMP_EN
    dump_req = 0; dump_ready = 0;
`endif
    tick();
    rst = 0;
    for (int i = 1; i < 32; i++) begin
      we = 1; waddr = 5'(i); wdata = 32'h100 + i;
      tick();
    end
    we = 0; re1 = 1; re2 = 1; raddr1 = 5'd31; raddr2 = 5'd1;
    #1;
    chk("load_r31", rdata1, 32'h11F);
    chk("load_r1", rdata2, 32'h101);

`ifdef REGFILE_DUMP_EN
    // Full dump, ready held high.
    dump_req = 1;
    #1;
    check_all();
    tick();
    dump_req = 0; dump_ready = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("beat_valid", {31'd0, dump_valid}, 32'd1);
      chk("beat_addr", {27'd0, dump_addr}, i);
      chk("beat_data", dump_data, (i == 0) ? 32'd0 : 32'h100 + i);
      // Re-request on the final handshake must be ignored.
      dump_req = (i == 31);
      check_all();
      tick();
    end
    dump_req = 0;
    #1;
    chk("full_busy_end", {31'd0, dump_busy}, 32'd0);
    chk("full_valid_end", {31'd0, dump_valid}, 32'd0);

    // Stall at idx 7 while r7 is rewritten.
    dump_req = 1;
    tick();
    dump_req = 0; dump_ready = 1;
    repeat (7) tick();
    dump_ready = 0; we = 1; waddr = 5'd7; wdata = 32'hCAFEF00D;
    #1;
    chk("stall_addr", {27'd0, dump_addr}, 32'd7);
    chk("stall_byp_data", dump_data, 32'hCAFEF00D);
    check_all();
    tick();
    we = 0; dump_req = 1;
    #1;
    chk("stall_addr2", {27'd0, dump_addr}, 32'd7);
    chk("stall_data2", dump_data, 32'hCAFEF00D);
    check_all();
    tick();
    dump_req = 0;
    #1;
    chk("stall_req_ign", {27'd0, dump_addr}, 32'd7);
    chk("stall_valid", {31'd0, dump_valid}, 32'd1);
    dump_ready = 1;
    for (int n = 0; n < 40 && d_active; n++) begin
      #1;
      check_all();
      tick();
    end
    #1;
    chk("stall_busy_end", {31'd0, dump_busy}, 32'd0);

    // Reset aborts a dump at idx 12.
    dump_req = 1;
    tick();
    dump_req = 0; dump_ready = 1;
    repeat (12) tick();
    #1;
    chk("pre_rst_addr", {27'd0, dump_addr}, 32'd12);
    rst = 1;
    #1;
    chk("in_rst_valid", {31'd0, dump_valid}, 32'd0);
    tick();
    rst = 0;
    #1;
    chk("post_rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, dump_busy}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(a);
      #1;
      chk("post_rst_rd1", rdata1, 32'd0);
      chk("post_rst_rd2", rdata2, 32'd0);
    end
    tick();
    chk("idle_no_beat", {31'd0, dump_valid}, 32'd0);
    dump_req = 1;
    tick();
    dump_req = 0;
    #1;
    chk("restart_valid", {31'd0, dump_valid}, 32'd1);
    chk("restart_addr", {27'd0, dump_addr}, 32'd0);
    for (int n = 0; n < 40 && d_active; n++) begin
      #1;
      check_all();
      tick();
    end
    #1;
    chk("restart_busy_end", {31'd0, dump_busy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
